// File: rtl/y_int_ctl_pkg.sv
// Shared definitions for the yChip interrupt controller: FSM encodings,
// default vector constants and the vector address helper.
package y_int_ctl_pkg;

    // FSM state encodings, shared with the yChip bench
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_FIRE = 2'd2;
    localparam logic [1:0] ST_SVC  = 2'd3;

    // Default vector layout
    localparam logic [31:0] DEF_BOOT_VEC   = 32'd128;
    localparam logic [31:0] DEF_VEC_BASE   = 32'd256;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'd16;

    // Vector of a source; plain 32-bit unsigned math, wraps on overflow
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] id);
        return base + id * stride;
    endfunction

endpackage

// File: rtl/y_int_ctl_prio.sv
// Fixed-priority find-first-set: lowest set bit wins.
module y_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          vld
);

    // Scan from the top down so the lowest set index is the last writer
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/y_int_ctl.sv
// yChip interrupt controller: edge-captured pending bits, mask, fixed
// priority arbitration and a non-nesting BOOT/IDLE/FIRE/SERVICE FSM that
// strobes INT for one cycle with the vector the CPU should load.
module y_int_ctl
    import y_int_ctl_pkg::*;
#(
    parameter int          NSRC       = 4,
    parameter logic [31:0] BOOT_VEC   = DEF_BOOT_VEC,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
    parameter int          IDW        = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic            maskWe,
    input  logic [NSRC-1:0] maskD,
    input  logic            eoi,
    output logic            INT,
    output logic [31:0]     entryPoint,
    output logic [IDW-1:0]  intId,
    output logic            busy
);

    logic [1:0]      state;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] clr;
    logic [IDW-1:0]  win_id;
    logic            win_vld;
    logic            take;

    // Edges are ignored while booting so levels held through reset
    // only count once they are lowered and raised again.
    assign edges = (state == ST_BOOT) ? '0 : (irq & ~irq_q);
    assign cand  = pend & mask;
    assign take  = (state == ST_IDLE) && win_vld;
    assign busy  = (state == ST_FIRE) || (state == ST_SVC);

    y_prio_enc #(.N(NSRC), .IW(IDW)) u_prio (
        .req (cand),
        .idx (win_id),
        .vld (win_vld)
    );

    // One-hot clear of the source being dispatched this cycle
    always_comb begin
        clr = '0;
        if (take)
            clr = NSRC'(1) << win_id;
    end

    // Edge capture, pending set/clear (clear wins) and mask register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
            pend  <= '0;
            mask  <= '1;
        end else begin
            irq_q <= irq;
            pend  <= (pend | edges) & ~clr;
            if (maskWe)
                mask <= maskD;
        end
    end

    // Dispatch FSM; INT is a registered one-cycle strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_BOOT;
            INT        <= 1'b0;
            entryPoint <= BOOT_VEC;
            intId      <= '0;
        end else begin
            INT <= 1'b0;
            case (state)
                ST_BOOT: begin
                    if (!INT) begin
                        INT        <= 1'b1;
                        entryPoint <= BOOT_VEC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (win_vld) begin
                        state      <= ST_FIRE;
                        INT        <= 1'b1;
                        intId      <= win_id;
                        entryPoint <= vec_addr(VEC_BASE, VEC_STRIDE, 32'(win_id));
                    end
                end
                ST_FIRE: state <= ST_SVC;
                ST_SVC: begin
                    if (eoi)
                        state <= ST_IDLE;
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_y_int_ctl.sv
// Bench for y_int_ctl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_y_int_ctl;

    localparam int          N   = 4;
    localparam logic [31:0] BV  = 32'd128;
    localparam logic [31:0] VB  = 32'd256;
    localparam logic [31:0] VS  = 32'd16;

    logic         clk;
    logic         reset;
    logic [N-1:0] irq;
    logic         maskWe;
    logic [N-1:0] maskD;
    logic         eoi;
    logic         INT;
    logic [31:0]  entryPoint;
    logic [1:0]   intId;
    logic         busy;

    int total = 0;
    int bad   = 0;

    y_int_ctl #(.NSRC(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .maskWe     (maskWe),
        .maskD      (maskD),
        .eoi        (eoi),
        .INT        (INT),
        .entryPoint (entryPoint),
        .intId      (intId),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // since: edges seen since reset (saturating); first two belong to boot.
    int           since;
    logic [N-1:0] p, prev, msk, ed, cand, clrm;
    int           win;
    logic         m_int, m_fire, m_svc;
    logic [31:0]  m_ep;
    int           m_id;

    always @(posedge clk) begin
        if (reset) begin
            since = 0; p = '0; prev = '0; msk = '1;
            m_int = 0; m_fire = 0; m_svc = 0; m_ep = BV; m_id = 0;
        end else begin
            if (since < 3) since++;
            ed   = irq & ~prev;
            prev = irq;
            cand = p & msk;
            clrm = '0;
            win  = -1;
            for (int i = N - 1; i >= 0; i--) if (cand[i]) win = i;
            m_int = 0;
            if (since == 1) begin
                m_int = 1; m_ep = BV;
            end else if (since == 2) begin
                m_int = 0;
            end else if (m_fire) begin
                m_fire = 0; m_svc = 1;
            end else if (m_svc) begin
                if (eoi) m_svc = 0;
            end else if (win >= 0) begin
                m_int = 1; m_fire = 1; m_id = win;
                m_ep = VB + 32'(win) * VS;
                clrm[win] = 1'b1;
            end
            if (since <= 2) ed = '0;
            p = (p | ed) & ~clrm;
            if (maskWe) msk = maskD;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("int",   32'(INT),        32'(m_int));
        chk("ep",    entryPoint,      m_ep);
        chk("id",    32'(intId),      32'(m_id));
        chk("busy",  32'(busy),       32'(m_fire | m_svc));
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Steps until INT is seen; c = cycles taken, 0 if none within budget
    task automatic wait_int(input int maxc, output int c);
        c = 0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (INT) begin
                c = i;
                return;
            end
        end
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    int c;

    initial begin
        reset = 1'b1; irq = '0; maskWe = 1'b0; maskD = '0; eoi = 1'b0;
        repeat (3) step();
        chk("rst_int",  32'(INT), 0);
        chk("rst_ep",   entryPoint, 128);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_id",   32'(intId), 0);

        // boot vector for exactly one cycle
        reset = 1'b0;
        step();
        chk("boot_int", 32'(INT), 1);
        chk("boot_ep",  entryPoint, 128);
        step();
        chk("boot_end", 32'(INT), 0);
        chk("boot_busy", 32'(busy), 0);
        step();

        // single source, two-cycle latency
        irq = 4'b0100;
        wait_int(5, c);
        chk("s2_lat", 32'(c), 2);
        chk("s2_ep",  entryPoint, 288);
        chk("s2_id",  32'(intId), 2);
        chk("s2_model_ep", m_ep, 288);
        step();
        chk("s2_one", 32'(INT), 0);
        chk("s2_busy", 32'(busy), 1);
        pulse_eoi();
        chk("s2_done", 32'(busy), 0);
        irq = '0;
        step();

        // priority and back-to-back dispatch
        irq = 4'b1010;
        wait_int(5, c);
        chk("pr_ep1", entryPoint, 272);
        chk("pr_id1", 32'(intId), 1);
        step();
        pulse_eoi();
        wait_int(3, c);
        chk("pr_lat2", 32'(c), 1);
        chk("pr_ep2", entryPoint, 304);
        chk("pr_model_id", 32'(m_id), 3);
        step();
        pulse_eoi();
        irq = '0;
        step();

        // masking holds a pending source until unmasked
        maskWe = 1'b1; maskD = 4'b1110;
        step();
        maskWe = 1'b0;
        irq = 4'b0001;
        wait_int(6, c);
        chk("mask_none", 32'(c), 0);
        maskWe = 1'b1; maskD = 4'b1111;
        step();
        maskWe = 1'b0;
        wait_int(3, c);
        chk("mask_lat", 32'(c), 1);
        chk("mask_ep", entryPoint, 256);
        step();
        pulse_eoi();
        irq = '0;
        step();

        // repeated edges while in service collapse to one
        irq = 4'b0010;
        wait_int(5, c);
        chk("tg_ep1", entryPoint, 272);
        step();
        irq = 4'b0000; step();
        irq = 4'b0010; step();
        irq = 4'b0000; step();
        irq = 4'b0010; step();
        pulse_eoi();
        wait_int(3, c);
        chk("tg_lat", 32'(c), 1);
        chk("tg_ep2", entryPoint, 272);
        step();
        pulse_eoi();
        wait_int(6, c);
        chk("tg_once", 32'(c), 0);
        irq = '0;
        step();

        // reset mid-service discards in-service and pending work
        irq = 4'b0010;
        wait_int(5, c);
        step();
        irq = 4'b0110;
        step(); step();
        reset = 1'b1;
        step(); step();
        chk("mr_busy", 32'(busy), 0);
        reset = 1'b0;
        step();
        chk("mr_boot", entryPoint, 128);
        chk("mr_int",  32'(INT), 1);
        wait_int(8, c);
        chk("mr_nofire", 32'(c), 0);
        irq = 4'b0010;
        step();
        irq = 4'b0110;
        wait_int(4, c);
        chk("mr_refire", entryPoint, 288);
        step();
        pulse_eoi();
        irq = '0;
        step();

        // randomized traffic, checked by the model each cycle
        for (int i = 0; i < 3000; i++) begin
            irq    = N'($urandom);
            maskWe = ($urandom_range(7) == 0);
            maskD  = N'($urandom);
            eoi    = ($urandom_range(2) == 0);
            reset  = ($urandom_range(499) == 0);
            step();
        end
        reset = 1'b0; maskWe = 1'b0; eoi = 1'b0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
